// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared ALU opcodes and shift-add multiplier state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam logic [3:0] OP_BYPASS    = 4'b0000;
   localparam logic [3:0] OP_LLS_SUPER = 4'b0010;
   localparam logic [3:0] OP_RLS_RX    = 4'b0101;
   localparam logic [3:0] OP_ADD       = 4'b1110;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADD  = 3'd1,
      SHL  = 3'd2,
      SHR  = 3'd3,
      DONE = 3'd4
   } mul_state_t;

   // First operation state for a freshly accepted multiplier value.
   function automatic mul_state_t first_state(input logic [7:0] mplier);
      if (mplier == 8'd0)
         return DONE;
      else if (mplier[0])
         return ADD;
      else
         return SHL;
   endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_mul_seq
// Description : 8x8 shift-add multiplier that sequences an external ALU,
//               one ALU operation per cycle, with valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mul_seq
   import alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       resp_valid,
   input  logic       resp_ready,
   output logic [7:0] product,
   output logic       ovf,
   output logic [3:0] alu_opcode,
   output logic [7:0] input0,
   output logic [7:0] input1,
   input  logic [7:0] result,
   input  logic       zero
);

   mul_state_t r_state;
   mul_state_t w_state_nxt;

   logic [7:0] r_acc;
   logic [7:0] r_mcand;
   logic [7:0] r_mplier;
   logic       r_lost;
   logic       r_ovf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      alu_opcode  = OP_BYPASS;
      input0      = 8'd0;
      input1      = 8'd0;
      case (r_state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               w_state_nxt = first_state(b);
         end
         ADD: begin
            alu_opcode  = OP_ADD;
            input0      = r_acc;
            input1      = r_mcand;
            w_state_nxt = SHL;
         end
         SHL: begin
            alu_opcode  = OP_LLS_SUPER;
            input0      = r_mcand;
            w_state_nxt = SHR;
         end
         SHR: begin
            alu_opcode = OP_RLS_RX;
            input1     = r_mplier;
            // The shifted multiplier comes straight back from the ALU.
            if (zero)
               w_state_nxt = DONE;
            else if (result[0])
               w_state_nxt = ADD;
            else
               w_state_nxt = SHL;
         end
         DONE: begin
            resp_valid = 1'b1;
            if (resp_ready)
               w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc    <= 8'd0;
         r_mcand  <= 8'd0;
         r_mplier <= 8'd0;
         r_lost   <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_acc    <= 8'd0;
                  r_mcand  <= a;
                  r_mplier <= b;
                  r_lost   <= 1'b0;
                  r_ovf    <= 1'b0;
               end
            end
            ADD: begin
               r_acc <= result;
               // Wrap-around of the sum, or adding a multiplicand that has
               // already shifted a one out of the top, both mean overflow.
               if ((result < r_acc) || r_lost)
                  r_ovf <= 1'b1;
            end
            SHL: begin
               r_mcand <= result;
               r_lost  <= r_lost | r_mcand[7];
            end
            SHR: begin
               r_mplier <= result;
            end
            default: begin
            end
         endcase
      end
   end

   assign product = r_acc;
   assign ovf     = r_ovf;

endmodule : alu_mul_seq
`default_nettype wire

// File: tb/tb_alu_mul_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mul_seq
// Description : Self-checking bench for alu_mul_seq with an external ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mul_seq;

   logic       clk;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [7:0] a;
   logic [7:0] b;
   logic       resp_valid;
   logic       resp_ready;
   logic [7:0] product;
   logic       ovf;
   logic [3:0] alu_opcode;
   logic [7:0] input0;
   logic [7:0] input1;
   logic [7:0] result;
   logic       zero;

   int n_checks = 0;
   int n_errors = 0;

   alu_mul_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .a          (a),
      .b          (b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .product    (product),
      .ovf        (ovf),
      .alu_opcode (alu_opcode),
      .input0     (input0),
      .input1     (input1),
      .result     (result),
      .zero       (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External ALU: combinational, same cycle.
   always_comb begin
      case (alu_opcode)
         4'b1110: result = input0 + input1;
         4'b0010: result = {input0[6:0], 1'b0};
         4'b0101: result = {1'b0, input1[7:1]};
         default: result = input0;
      endcase
      zero = (result == 8'd0);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: product is a*b, busy time follows the bit pattern of b.
   function automatic int lat_of(input logic [7:0] v);
      int msb = -1;
      int nset = 0;
      for (int i = 0; i < 8; i++)
         if (v[i]) begin
            msb = i;
            nset++;
         end
      if (msb < 0) return 0;
      return 3 * nset + 2 * (msb + 1 - nset);
   endfunction

   int         m_phase;   // 0 idle, 1 busy, 2 response pending
   int         m_cnt;
   logic [7:0] m_prod;
   logic       m_ovf;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase <= 0;
         m_cnt   <= 0;
         m_prod  <= 8'd0;
         m_ovf   <= 1'b0;
      end else begin
         case (m_phase)
            0: if (req_valid) begin
               m_prod <= 8'((int'(a) * int'(b)) & 255);
               m_ovf  <= (int'(a) * int'(b)) > 255;
               if (lat_of(b) == 0) m_phase <= 2;
               else begin
                  m_phase <= 1;
                  m_cnt   <= lat_of(b);
               end
            end
            1: begin
               if (m_cnt == 1) m_phase <= 2;
               m_cnt <= m_cnt - 1;
            end
            default: if (resp_ready) m_phase <= 0;
         endcase
      end
   end

   always @(negedge clk) begin
      check("req_ready", 32'(req_ready), 32'(m_phase == 0));
      check("resp_valid", 32'(resp_valid), 32'(m_phase == 2));
      if (m_phase != 1) begin
         check("product", 32'(product), 32'(m_prod));
         check("ovf", 32'(ovf), 32'(m_ovf));
         check("opcode_idle", 32'(alu_opcode), 32'h0);
         check("operands_idle", {16'd0, input0, input1}, 32'h0);
      end else begin
         check("opcode_busy",
               32'((alu_opcode == 4'b1110) || (alu_opcode == 4'b0010) || (alu_opcode == 4'b0101)),
               32'h1);
      end
   end

   // Issue one request, check literal latency/result, hold DONE, handshake.
   task automatic do_mul(input logic [7:0] ta, input logic [7:0] tb_, input logic [7:0] ep,
                         input logic eo, input int elat, input int hold);
      int k;
      logic [7:0] held;
      k = 0;
      while (!req_ready && k < 50) begin
         @(posedge clk); #1;
         k++;
      end
      check("ready_before_req", 32'(req_ready), 32'h1);
      req_valid = 1'b1;
      a = ta;
      b = tb_;
      @(posedge clk); #1;
      req_valid = 1'b0;
      a = 8'hA5;
      b = 8'h3C;
      k = 0;
      while (!resp_valid && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      check("latency", 32'(k), 32'(elat));
      check("lit_product", 32'(product), 32'(ep));
      check("lit_ovf", 32'(ovf), 32'(eo));
      held = product;
      for (int i = 0; i < hold; i++) begin
         req_valid = i[0];
         a = 8'h11;
         b = 8'h01;
         @(posedge clk); #1;
         check("hold_valid", 32'(resp_valid), 32'h1);
         check("hold_product", 32'(product), 32'(held));
         check("hold_ready", 32'(req_ready), 32'h0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("idle_after_hs", 32'(req_ready), 32'h1);
      check("idle_product", 32'(product), 32'(ep));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      a          = 8'd0;
      b          = 8'd0;
      #12;
      check("rst_product", 32'(product), 32'h0);
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_req_ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      do_mul(8'h03, 8'h05, 8'h0F, 1'b0, 8, 0);
      do_mul(8'hFF, 8'h03, 8'hFD, 1'b1, 6, 0);
      do_mul(8'h80, 8'h02, 8'h00, 1'b1, 5, 0);
      do_mul(8'h80, 8'h01, 8'h80, 1'b0, 3, 0);
      do_mul(8'h55, 8'h00, 8'h00, 1'b0, 0, 0);
      do_mul(8'h0F, 8'h11, 8'hFF, 1'b0, 12, 0);
      do_mul(8'hFF, 8'hFF, 8'h01, 1'b1, 24, 0);
      do_mul(8'h10, 8'h10, 8'h00, 1'b1, 11, 0);
      do_mul(8'h03, 8'h05, 8'h0F, 1'b0, 8, 5);

      // Abort mid-operation: a=7,b=0xFF is in SHL two edges after the request.
      req_valid = 1'b1;
      a = 8'h07;
      b = 8'hFF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("mid_shl_opcode", 32'(alu_opcode), 32'h2);
      rst_n = 1'b0;
      #1;
      check("abort_opcode", 32'(alu_opcode), 32'h0);
      check("abort_operands", {16'd0, input0, input1}, 32'h0);
      check("abort_product", 32'(product), 32'h0);
      check("abort_ovf", 32'(ovf), 32'h0);
      check("abort_resp_valid", 32'(resp_valid), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("release_ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      check("no_stale_resp", 32'(resp_valid), 32'h0);
      do_mul(8'h02, 8'h04, 8'h08, 1'b0, 7, 0);

      @(posedge clk); #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_alu_mul_seq
`default_nettype wire
